// File: rtl/stbuf_be.sv
// Store buffer with byte-enable stores, byte-granular load forwarding,
// speculative flush of uncommitted stores and a valid/ack retire port.
module stbuf_be #(
  parameter int ENT_NUM    = 8,
  parameter int ENT_SEL    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_exfin_st,
  input  logic [ADDR_WIDTH-1:0]   i_exfin_st_addr,
  input  logic [DATA_WIDTH-1:0]   i_exfin_st_data,
  input  logic [DATA_WIDTH/8-1:0] i_exfin_st_be,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ENT_SEL:0]        o_count,
  input  logic                    i_com_stbuf,
  input  logic                    i_flush,
  output logic                    o_ret_stbuf,
  input  logic                    i_ret_ack,
  output logic [ADDR_WIDTH-1:0]   o_ret_stbuf_addr,
  output logic [DATA_WIDTH-1:0]   o_ret_stbuf_data,
  output logic [DATA_WIDTH/8-1:0] o_ret_stbuf_be,
  input  logic [ADDR_WIDTH-1:0]   i_ld_addr,
  input  logic [DATA_WIDTH/8-1:0] i_ld_be,
  output logic                    o_stbuf_fwd_hit,
  output logic                    o_stbuf_fwd_partial,
  output logic [DATA_WIDTH-1:0]   o_stbuf_rd_data
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int OFF  = $clog2(BE_W);

  typedef logic [ENT_SEL:0] ptr_t;

  ptr_t ret_ptr, com_ptr, fin_ptr, com_ptr_nxt, count;
  logic [ENT_SEL-1:0] ret_idx, com_idx, fin_idx;
  logic [ENT_NUM-1:0] vld, com, vld_nxt, com_nxt;
  logic alloc, do_com, do_ret;

  logic [ADDR_WIDTH-1:0] addr_q [ENT_NUM];
  logic [DATA_WIDTH-1:0] data_q [ENT_NUM];
  logic [BE_W-1:0]       be_q   [ENT_NUM];

  logic [BE_W-1:0]       cov;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  unused_ld_addr;

  assign ret_idx = ret_ptr[ENT_SEL-1:0];
  assign com_idx = com_ptr[ENT_SEL-1:0];
  assign fin_idx = fin_ptr[ENT_SEL-1:0];

  assign count   = fin_ptr - ret_ptr;
  assign o_count = count;
  assign o_full  = (count == ptr_t'(ENT_NUM));
  assign o_empty = (count == '0);

  assign o_ret_stbuf      = vld[ret_idx] & com[ret_idx];
  assign o_ret_stbuf_addr = addr_q[ret_idx];
  assign o_ret_stbuf_data = data_q[ret_idx];
  assign o_ret_stbuf_be   = be_q[ret_idx];

  // A flushed store never allocates, so the flush target below stays exact.
  assign alloc       = i_exfin_st & ~o_full & ~i_flush;
  assign do_com      = i_com_stbuf & (com_ptr != fin_ptr);
  assign do_ret      = o_ret_stbuf & i_ret_ack;
  assign com_ptr_nxt = com_ptr + ptr_t'(do_com);

  // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    vld_nxt = vld;
    com_nxt = com;
    if (do_com) com_nxt[com_idx] = 1'b1;
    if (do_ret) begin
      vld_nxt[ret_idx] = 1'b0;
      com_nxt[ret_idx] = 1'b0;
    end
    // Valid-but-uncommitted entries are exactly [com_ptr_nxt, fin_ptr).
    if (i_flush) vld_nxt = vld_nxt & com_nxt;
    if (alloc)   vld_nxt[fin_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_ptr <= '0;
      com_ptr <= '0;
      fin_ptr <= '0;
      vld     <= '0;
      com     <= '0;
    end else begin
      ret_ptr <= ret_ptr + ptr_t'(do_ret);
      com_ptr <= com_ptr_nxt;
      fin_ptr <= i_flush ? com_ptr_nxt : fin_ptr + ptr_t'(alloc);
      vld     <= vld_nxt;
      com     <= com_nxt;
    end
  end

  // NOTE: payload arrays are not reset; nothing reads them unless the entry's vld bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[fin_idx] <= i_exfin_st_addr;
      data_q[fin_idx] <= i_exfin_st_data;
      be_q[fin_idx]   <= i_exfin_st_be;
    end
  end

  // Walk oldest to youngest from the head so the youngest matching lane wins, wrap included.
  always_comb begin : fwd_search
    logic [ENT_SEL-1:0] idx;
    logic [BE_W-1:0]    sel;
    cov      = '0;
    fwd_data = '0;
    idx      = '0;
    sel      = '0;
    for (int k = 0; k < ENT_NUM; k++) begin
      idx = ret_idx + ENT_SEL'(k);
      sel = be_q[idx] & i_ld_be;
      if (vld[idx] && (addr_q[idx][ADDR_WIDTH-1:OFF] == i_ld_addr[ADDR_WIDTH-1:OFF])) begin
        for (int b = 0; b < BE_W; b++) begin
          if (sel[b]) begin
            cov[b]           = 1'b1;
            fwd_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
          end
        end
      end
    end
  end

  assign o_stbuf_fwd_hit     = (i_ld_be != '0) && (cov == i_ld_be);
  assign o_stbuf_fwd_partial = (cov != '0) && !o_stbuf_fwd_hit;
  assign o_stbuf_rd_data     = fwd_data;

  // Byte-offset bits of the load address do not take part in the word match.
  assign unused_ld_addr = ^i_ld_addr;

endmodule

// File: tb/tb_stbuf_be.sv
// Directed bench for stbuf_be: fill/drain, retire stall, byte-merge forwarding,
// youngest-wins across wrap, flush with same-cycle store/commit, async reset.
module tb_stbuf_be;

  logic        clk, rst;
  logic        i_exfin_st;
  logic [31:0] i_exfin_st_addr, i_exfin_st_data;
  logic [3:0]  i_exfin_st_be;
  logic        o_full, o_empty;
  logic [3:0]  o_count;
  logic        i_com_stbuf, i_flush, o_ret_stbuf, i_ret_ack;
  logic [31:0] o_ret_stbuf_addr, o_ret_stbuf_data;
  logic [3:0]  o_ret_stbuf_be;
  logic [31:0] i_ld_addr;
  logic [3:0]  i_ld_be;
  logic        o_stbuf_fwd_hit, o_stbuf_fwd_partial;
  logic [31:0] o_stbuf_rd_data;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        hit;
    logic        part;
    logic [31:0] data;
  } ld_vec_t;

  ld_vec_t vecs [8];

  stbuf_be dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_exfin_st          (i_exfin_st),
    .i_exfin_st_addr     (i_exfin_st_addr),
    .i_exfin_st_data     (i_exfin_st_data),
    .i_exfin_st_be       (i_exfin_st_be),
    .o_full              (o_full),
    .o_empty             (o_empty),
    .o_count             (o_count),
    .i_com_stbuf         (i_com_stbuf),
    .i_flush             (i_flush),
    .o_ret_stbuf         (o_ret_stbuf),
    .i_ret_ack           (i_ret_ack),
    .o_ret_stbuf_addr    (o_ret_stbuf_addr),
    .o_ret_stbuf_data    (o_ret_stbuf_data),
    .o_ret_stbuf_be      (o_ret_stbuf_be),
    .i_ld_addr           (i_ld_addr),
    .i_ld_be             (i_ld_be),
    .o_stbuf_fwd_hit     (o_stbuf_fwd_hit),
    .o_stbuf_fwd_partial (o_stbuf_fwd_partial),
    .o_stbuf_rd_data     (o_stbuf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    i_exfin_st      = 1'b1;
    i_exfin_st_addr = a;
    i_exfin_st_data = d;
    i_exfin_st_be   = be;
    step();
    i_exfin_st      = 1'b0;
  endtask

  task automatic commit_n(input int n);
    i_com_stbuf = 1'b1;
    repeat (n) step();
    i_com_stbuf = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be);
    i_ld_addr = a;
    i_ld_be   = be;
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h200, 4'h3, 1'b1, 1'b0, 32'h0000BBAA};
    vecs[1] = '{32'h200, 4'hF, 1'b0, 1'b1, 32'h0000BBAA};
    vecs[2] = '{32'h203, 4'h3, 1'b1, 1'b0, 32'h0000BBAA};
    vecs[3] = '{32'h200, 4'h4, 1'b0, 1'b0, 32'h00000000};
    vecs[4] = '{32'h204, 4'hF, 1'b1, 1'b0, 32'h55223344};
    vecs[5] = '{32'h204, 4'h8, 1'b1, 1'b0, 32'h55000000};
    vecs[6] = '{32'h208, 4'hF, 1'b0, 1'b0, 32'h00000000};
    vecs[7] = '{32'h200, 4'h0, 1'b0, 1'b0, 32'h00000000};

    rst = 1'b1;
    i_exfin_st = 1'b0; i_exfin_st_addr = '0; i_exfin_st_data = '0; i_exfin_st_be = '0;
    i_com_stbuf = 1'b0; i_flush = 1'b0; i_ret_ack = 1'b0;
    i_ld_addr = '0; i_ld_be = 4'hF;
    #1;
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_count", o_count, 0);
    check("rst_ret", o_ret_stbuf, 0);
    check("rst_hit", o_stbuf_fwd_hit, 0);
    check("rst_partial", o_stbuf_fwd_partial, 0);
    step();
    rst = 1'b0;

    // Fill and drain
    for (int k = 0; k < 8; k++) store(32'h100 + 32'(4 * k), 32'(k), 4'hF);
    check("fill_full", o_full, 1);
    check("fill_count", o_count, 8);
    store(32'h999, 32'd99, 4'hF);
    check("ninth_ignored_count", o_count, 8);
    commit_n(8);
    check("fill_ret_ready", o_ret_stbuf, 1);
    i_ret_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_ret[%0d]", k), o_ret_stbuf, 1);
      check($sformatf("drain_addr[%0d]", k), o_ret_stbuf_addr, 32'h100 + 32'(4 * k));
      check($sformatf("drain_data[%0d]", k), o_ret_stbuf_data, 32'(k));
      step();
    end
    i_ret_ack = 1'b0;
    check("drain_empty", o_empty, 1);
    check("drain_count", o_count, 0);
    check("drain_ret_off", o_ret_stbuf, 0);

    // Retire stall
    store(32'h400, 32'hDEADBEEF, 4'h5);
    commit_n(1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_ret[%0d]", c), o_ret_stbuf, 1);
      check($sformatf("stall_addr[%0d]", c), o_ret_stbuf_addr, 32'h400);
      check($sformatf("stall_data[%0d]", c), o_ret_stbuf_data, 32'hDEADBEEF);
      check($sformatf("stall_be[%0d]", c), o_ret_stbuf_be, 4'h5);
      step();
    end
    i_ret_ack = 1'b1;
    check("stall_ack_ret", o_ret_stbuf, 1);
    step();
    i_ret_ack = 1'b0;
    check("stall_after_ret", o_ret_stbuf, 0);
    check("stall_after_empty", o_empty, 1);

    // Byte-merge forwarding table
    store(32'h200, 32'h000000AA, 4'h1);
    store(32'h201, 32'h0000BB00, 4'h2);
    store(32'h204, 32'h11223344, 4'hF);
    store(32'h204, 32'h55000000, 4'h8);
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].addr, vecs[i].be);
      check($sformatf("fwd_hit[%0d]", i), o_stbuf_fwd_hit, vecs[i].hit);
      check($sformatf("fwd_partial[%0d]", i), o_stbuf_fwd_partial, vecs[i].part);
      check($sformatf("fwd_data[%0d]", i), o_stbuf_rd_data, vecs[i].data);
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("merge_flush_empty", o_empty, 1);
    load(32'h200, 4'h3);
    check("merge_flush_nohit", o_stbuf_fwd_hit, 0);

    // Youngest wins across wrap: advance pointers to entry 6
    repeat (5) begin
      store(32'h500, 32'h0, 4'hF);
      commit_n(1);
      i_ret_ack = 1'b1;
      step();
      i_ret_ack = 1'b0;
    end
    check("wrap_pre_empty", o_empty, 1);
    store(32'h300, 32'd1, 4'hF);
    store(32'h300, 32'd2, 4'hF);
    store(32'h300, 32'd3, 4'hF);
    check("wrap_count", o_count, 3);
    load(32'h300, 4'hF);
    check("wrap_hit", o_stbuf_fwd_hit, 1);
    check("wrap_partial", o_stbuf_fwd_partial, 0);
    check("wrap_data", o_stbuf_rd_data, 32'd3);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("wrap_flush_empty", o_empty, 1);

    // Flush with a same-cycle store and commit
    for (int k = 0; k < 4; k++) store(32'h600 + 32'(4 * k), 32'h60 + 32'(k), 4'hF);
    commit_n(2);
    i_flush = 1'b1;
    i_com_stbuf = 1'b1;
    i_exfin_st = 1'b1; i_exfin_st_addr = 32'h700; i_exfin_st_data = 32'h77; i_exfin_st_be = 4'hF;
    step();
    i_flush = 1'b0; i_com_stbuf = 1'b0; i_exfin_st = 1'b0;
    check("flush_count", o_count, 3);
    load(32'h60C, 4'hF);
    check("flush_gone_hit", o_stbuf_fwd_hit, 0);
    check("flush_gone_partial", o_stbuf_fwd_partial, 0);
    load(32'h700, 4'hF);
    check("flush_dropped_hit", o_stbuf_fwd_hit, 0);
    load(32'h608, 4'hF);
    check("flush_kept_hit", o_stbuf_fwd_hit, 1);
    check("flush_kept_data", o_stbuf_rd_data, 32'h62);
    i_ret_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("flush_ret[%0d]", k), o_ret_stbuf, 1);
      check($sformatf("flush_ret_data[%0d]", k), o_ret_stbuf_data, 32'h60 + 32'(k));
      step();
    end
    i_ret_ack = 1'b0;
    check("flush_ret_done", o_ret_stbuf, 0);
    check("flush_ret_empty", o_empty, 1);

    // Asynchronous reset between clock edges
    for (int k = 0; k < 5; k++) store(32'h800 + 32'(4 * k), 32'h80 + 32'(k), 4'hF);
    commit_n(2);
    check("arst_pre_count", o_count, 5);
    check("arst_pre_ret", o_ret_stbuf, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", o_empty, 1);
    check("arst_ret", o_ret_stbuf, 0);
    check("arst_count", o_count, 0);
    step();
    rst = 1'b0;
    store(32'h900, 32'h12, 4'hF);
    load(32'h900, 4'hF);
    check("post_rst_hit", o_stbuf_fwd_hit, 1);
    check("post_rst_data", o_stbuf_rd_data, 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stbuf_be.md
Name: stbuf_be

Overview:
- Parametrised store buffer with byte-enable stores, byte-granular load forwarding, speculative flush and a valid/ack retire handshake to the data memory.
- Sits between the LSU execute stage (finished stores), the ROB (commit and flush) and the dmem port (retire).
- Adds to the earlier store buffer: sub-word stores, partial-forward detection, flush of uncommitted stores, occupancy count and a stall-tolerant retire port.

Parameters:
- ENT_NUM, 8, number of entries; power of two, at least 2.
- ENT_SEL, 3, log2(ENT_NUM).
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; multiple of 8. BE_W = DATA_WIDTH/8, OFF = log2(BE_W).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_exfin_st  in  1  finished store; allocate at tail
- i_exfin_st_addr  in  ADDR_WIDTH  store address
- i_exfin_st_data  in  DATA_WIDTH  store data, lane-aligned
- i_exfin_st_be  in  BE_W  byte enables
- o_full  out  1  no free entry
- o_empty  out  1  no valid entry
- o_count  out  ENT_SEL+1  number of valid entries
- i_com_stbuf  in  1  commit the oldest uncommitted entry
- i_flush  in  1  discard all uncommitted entries
- o_ret_stbuf  out  1  head entry committed and offered to dmem
- i_ret_ack  in  1  dmem accepts the head entry
- o_ret_stbuf_addr  out  ADDR_WIDTH  head address
- o_ret_stbuf_data  out  DATA_WIDTH  head data
- o_ret_stbuf_be  out  BE_W  head byte enables
- i_ld_addr  in  ADDR_WIDTH  load address
- i_ld_be  in  BE_W  load byte lanes requested
- o_stbuf_fwd_hit  out  1  every requested lane is supplied by the buffer
- o_stbuf_fwd_partial  out  1  some requested lanes match, but not all; the load must stall
- o_stbuf_rd_data  out  DATA_WIDTH  forwarded data; lanes not supplied read 0

Behaviour:
- Storage and pointers
  - Circular buffer with three pointers: ret_ptr (head), com_ptr and fin_ptr (tail).
  - Each pointer is ENT_SEL+1 bits; the MSB is a wrap bit.
  - Invariant: ret_ptr <= com_ptr <= fin_ptr, measured modulo 2*ENT_NUM.
  - count = fin_ptr - ret_ptr. o_full = (count == ENT_NUM). o_empty = (count == 0). All three are combinational from registers.
- Reset
  - While rst is high (asynchronous assert), all pointers = 0 and all vld/com bits = 0.
  - Outputs during reset: o_empty=1, o_full=0, o_count=0, o_ret_stbuf=0, o_stbuf_fwd_hit=0, o_stbuf_fwd_partial=0.
  - The addr/data/be arrays are not reset; no output depends on them unless the matching vld bit is set.
- Allocate
  - When i_exfin_st && !o_full: write addr/data/be at fin_ptr, set its vld bit, fin_ptr+1.
  - i_exfin_st while o_full is ignored; upstream must not do this.
- Commit
  - When i_com_stbuf && com_ptr != fin_ptr: set com at com_ptr, com_ptr+1.
  - A commit with no finished uncommitted store is ignored.
- Retire
  - o_ret_stbuf = head entry has vld && com.
  - Head addr/data/be are held stable until the handshake.
  - On o_ret_stbuf && i_ret_ack: clear vld/com at ret_ptr, ret_ptr+1.
  - Throughput is 1 entry per cycle.
  - i_ret_ack without o_ret_stbuf is ignored.
- Flush
  - On i_flush: fin_ptr <= commit-adjusted com_ptr, and vld is cleared for every entry in [com_ptr, fin_ptr).
  - Committed entries are untouched.
- Same-cycle priority
  - Flush beats allocate: the incoming store is dropped.
  - Commit is applied before flush.
  - Retire is independent of both.
  - Allocate and retire in the same cycle when full: allocate is refused, because o_full is taken from registered state.
  - Allocate, commit and retire may all occur in one cycle.
- Forwarding (combinational, 0 cycles)
  - An entry matches when vld=1 and addr[ADDR_WIDTH-1:OFF] == i_ld_addr[ADDR_WIDTH-1:OFF].
  - For each lane b: search from youngest to oldest (fin_ptr-1 down to ret_ptr) for the first matching entry with be[b]=1; take that entry's byte b.
  - cov = the set of lanes found. o_stbuf_fwd_hit = (i_ld_be != 0) && ((cov & i_ld_be) == i_ld_be).
  - o_stbuf_fwd_partial = ((cov & i_ld_be) != 0) && !o_stbuf_fwd_hit.
  - Committed and uncommitted entries both forward.
  - The search order must wrap correctly when fin_ptr < ret_ptr in the low bits.

Test Plan:
- Fill and drain
  - Stimulus: reset, then 8 stores addr 0x100+4k, data k, be=0xF; commit 8; hold i_ret_ack=1.
  - Required: o_full=1 after the 8th store; a 9th store is ignored; retires occur in order k=0..7, one per cycle; ends with o_empty=1, o_count=0.
- Retire stall
  - Stimulus: 1 committed store, i_ret_ack=0 for 5 cycles.
  - Required: o_ret_stbuf=1 with addr/data/be stable for all 5 cycles; retires on the cycle ack=1; o_ret_stbuf=0 next cycle.
- Byte merge forwarding
  - Stimulus: store 0x200 data 0x000000AA be=0x1, then store 0x201 data 0x0000BB00 be=0x2; load 0x200 be=0x3.
  - Required: hit=1, rd_data=0x0000BBAA.
  - Then load be=0xF: partial=1, hit=0.
- Youngest wins across wrap
  - Stimulus: advance pointers to 6; stores to 0x300 with data 1, 2, 3 occupy entries 6, 7, 0.
  - Required: load 0x300 be=0xF returns 3, hit=1.
- Flush
  - Stimulus: 4 stores, commit 2, then i_flush together with a 5th store and a 3rd commit.
  - Required: o_count=3 next cycle; the 5th store is dropped; only 3 retires follow; a load to a flushed store's address gives hit=0.
- Async reset mid-operation
  - Stimulus: assert rst between clock edges with 5 entries valid.
  - Required: o_empty=1 and o_ret_stbuf=0 immediately, with no clock edge needed.
